// File: rtl/pipelined_divider.sv
// rtl/pipelined_divider.sv - restoring integer divider, one quotient bit per stage, throughput one op per cycle
// Optional two's-complement operation is enabled by defining DIVIDER_SIGNED_EN.
module pipelined_divider #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_dividend,
  input  logic [M-1:0]     in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_quotient,
  output logic [M-1:0]     out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0,
  output logic             out_ovf,
  output logic             busy
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // acc holds the not-yet-consumed dividend bits on top and the quotient bits shifted in below
  logic [N-1:0]     s_valid, c_valid;
  logic [N-1:0]     s_div0, c_div0;
  logic [M-1:0]     s_rem [N];
  logic [N-1:0]     s_acc [N];
  logic [M-1:0]     s_dsr [N];
  logic [TAG_W-1:0] s_tag [N];
  logic [M-1:0]     c_rem [N];
  logic [N-1:0]     c_acc [N];
  logic [M-1:0]     c_dsr [N];
  logic [TAG_W-1:0] c_tag [N];
  logic [M-1:0]     n_rem [N];
  logic [N-1:0]     n_acc [N];

  logic [N-1:0] f_dvd;
  logic [M-1:0] f_dsr;

`ifdef DIVIDER_SIGNED_EN
  logic [N-1:0] s_ovf, c_ovf, s_qneg, c_qneg, s_rneg, c_rneg;
  logic [M-1:0] s_dlo [N];
  logic [M-1:0] c_dlo [N];
  logic         f_ovf;

  assign f_dvd = in_dividend[N-1] ? -in_dividend : in_dividend;
  assign f_dsr = in_divisor[M-1] ? -in_divisor : in_divisor;
  assign f_ovf = (in_dividend == {1'b1, {(N-1){1'b0}}}) && (in_divisor == '1);
`else
  assign f_dvd = in_dividend;
  assign f_dsr = in_divisor;
`endif

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [M:0] r_sh;
    logic       ge;
    if (k == 0) begin : g_first
      assign c_valid[k] = in_valid;
      assign c_rem[k]   = '0;
      assign c_acc[k]   = f_dvd;
      assign c_dsr[k]   = f_dsr;
      assign c_tag[k]   = in_tag;
      assign c_div0[k]  = (in_divisor == '0);
`ifdef DIVIDER_SIGNED_EN
      assign c_ovf[k]   = f_ovf;
      assign c_qneg[k]  = in_dividend[N-1] ^ in_divisor[M-1];
      assign c_rneg[k]  = in_dividend[N-1];
      assign c_dlo[k]   = in_dividend[M-1:0];
`endif
    end else begin : g_chain
      assign c_valid[k] = s_valid[k-1];
      assign c_rem[k]   = s_rem[k-1];
      assign c_acc[k]   = s_acc[k-1];
      assign c_dsr[k]   = s_dsr[k-1];
      assign c_tag[k]   = s_tag[k-1];
      assign c_div0[k]  = s_div0[k-1];
`ifdef DIVIDER_SIGNED_EN
      assign c_ovf[k]   = s_ovf[k-1];
      assign c_qneg[k]  = s_qneg[k-1];
      assign c_rneg[k]  = s_rneg[k-1];
      assign c_dlo[k]   = s_dlo[k-1];
`endif
    end
    // compare at M+1 bits; the difference is below the divisor so M bits hold it exactly
    assign r_sh     = {c_rem[k], c_acc[k][N-1]};
    assign ge       = r_sh >= {1'b0, c_dsr[k]};
    assign n_rem[k] = ge ? (r_sh[M-1:0] - c_dsr[k]) : r_sh[M-1:0];
    assign n_acc[k] = {c_acc[k][N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_valid <= '0;
    end else if (adv) begin
      s_valid <= c_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        s_rem[k] <= n_rem[k];
        s_acc[k] <= n_acc[k];
        s_dsr[k] <= c_dsr[k];
        s_tag[k] <= c_tag[k];
`ifdef DIVIDER_SIGNED_EN
        s_dlo[k] <= c_dlo[k];
`endif
      end
      s_div0 <= c_div0;
`ifdef DIVIDER_SIGNED_EN
      s_ovf  <= c_ovf;
      s_qneg <= c_qneg;
      s_rneg <= c_rneg;
`endif
    end
  end

  logic [N-1:0] q_fin;
  logic [M-1:0] r_fin;

  always_comb begin
    q_fin = s_acc[N-1];
    r_fin = s_rem[N-1];
`ifdef DIVIDER_SIGNED_EN
    if (s_qneg[N-1]) q_fin = -s_acc[N-1];
    if (s_rneg[N-1]) r_fin = -s_rem[N-1];
    if (s_ovf[N-1]) begin
      q_fin = {1'b1, {(N-1){1'b0}}};
      r_fin = '0;
    end
    if (s_div0[N-1]) begin
      q_fin = '1;
      r_fin = s_dlo[N-1];
    end
`endif
  end

  // output fields load only with a valid result, so bubbles never disturb them
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_div0      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      out_ovf       <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= s_valid[N-1];
      if (s_valid[N-1]) begin
        out_quotient  <= q_fin;
        out_remainder <= r_fin;
        out_tag       <= s_tag[N-1];
        out_div0      <= s_div0[N-1];
`ifdef DIVIDER_SIGNED_EN
        out_ovf       <= s_ovf[N-1];
`endif
      end
    end
  end

`ifndef DIVIDER_SIGNED_EN
  assign out_ovf = 1'b0;
`endif

  assign busy = (|s_valid) || out_valid;

endmodule

// File: tb/tb_pipelined_divider.sv
// tb/tb_pipelined_divider.sv - table-driven bench for pipelined_divider with scoreboard and stall/reset sequences
module tb_pipelined_divider;
  localparam int N = 8;
  localparam int M = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_dividend;
  logic [M-1:0]     in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_quotient;
  logic [M-1:0]     out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             out_div0;
  logic             out_ovf;
  logic             busy;

  pipelined_divider #(.N(N), .M(M), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_div0(out_div0), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     dvd;
    logic [M-1:0]     dsr;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     q;
    logic [M-1:0]     r;
    logic             div0;
    logic             ovf;
  } vec_t;

  vec_t vec [32];
  int   nvec = 0;
  vec_t cur;
  vec_t sb [$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic vec_t mk(input int dvd, input int dsr, input int q, input int r,
                              input logic d0, input logic ov);
    vec_t v;
    v.dvd = dvd[N-1:0];
    v.dsr = dsr[M-1:0];
    v.tag = '0;
    v.q = q[N-1:0];
    v.r = r[M-1:0];
    v.div0 = d0;
    v.ovf = ov;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vec[nvec] = v;
    vec[nvec].tag = TAG_W'(nvec * 5 + 1);
    nvec++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one op and hold it until the handshake completes
  task automatic issue(input vec_t v);
    logic ok;
    cur = v;
    in_valid = 1'b1;
    in_dividend = v.dvd;
    in_divisor = v.dsr;
    in_tag = v.tag;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) return;
    end
    fail_now("issue_timeout", "in_ready never asserted");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    if (busy) fail_now("drain_timeout", "busy stuck high");
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin : monitor
    vec_t e;
    logic        prev_ok;
    logic        prev_valid;
    logic [31:0] prev_fields;
    prev_ok = 1'b0;
    prev_valid = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb.delete();
        prev_ok = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail_now("stale_result", $sformatf("unexpected result q=0x%0h tag=%0d", out_quotient, out_tag));
          end else begin
            e = sb.pop_front();
            check($sformatf("quotient %0h/%0h", e.dvd, e.dsr), 32'(out_quotient), 32'(e.q));
            check($sformatf("remainder %0h/%0h", e.dvd, e.dsr), 32'(out_remainder), 32'(e.r));
            check($sformatf("tag %0h/%0h", e.dvd, e.dsr), 32'(out_tag), 32'(e.tag));
            check($sformatf("div0 %0h/%0h", e.dvd, e.dsr), 32'(out_div0), 32'(e.div0));
            check($sformatf("ovf %0h/%0h", e.dvd, e.dsr), 32'(out_ovf), 32'(e.ovf));
          end
        end
        if (in_valid && in_ready) sb.push_back(cur);
        if (prev_ok && !out_valid && !prev_valid)
          check("idle_output_stable", {out_quotient, out_remainder, out_tag, out_div0, out_ovf}, prev_fields);
        prev_valid = out_valid;
        prev_fields = {out_quotient, out_remainder, out_tag, out_div0, out_ovf};
        prev_ok = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    int k;
    int run;
    int cnt;
    logic [31:0] cap;

    for (int i = 0; i < 8; i++) add(mk(i, 3, i / 3, i % 3, 1'b0, 1'b0));
    add(mk(37, 0, 8'hFF, 4'h5, 1'b1, 1'b0));
`ifndef DIVIDER_SIGNED_EN
    add(mk(255, 15, 17, 0, 1'b0, 1'b0));
    add(mk(200, 13, 15, 5, 1'b0, 1'b0));
    add(mk(255, 1, 255, 0, 1'b0, 1'b0));
    add(mk(14, 15, 0, 14, 1'b0, 1'b0));
    add(mk(255, 8, 31, 7, 1'b0, 1'b0));
`else
    add(mk(8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0));
    add(mk(8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1));
    add(mk(100, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0));
    add(mk(8'h80, 0, 8'hFF, 4'h0, 1'b1, 1'b0));
    add(mk(127, 4'hF, 8'h81, 4'h0, 1'b0, 1'b0));
    add(mk(8'hF9, 2, 8'hFD, 4'hF, 1'b0, 1'b0));
    add(mk(8'h85, 4'h8, 8'h0F, 4'hD, 1'b0, 1'b0));
`endif
    add(mk(9, 2, 4, 1, 1'b0, 1'b0));
    add(mk(100, 7, 14, 2, 1'b0, 1'b0));
    add(mk(0, 0, 8'hFF, 4'h0, 1'b1, 1'b0));
    add(mk(127, 7, 18, 1, 1'b0, 1'b0));
    add(mk(15, 7, 2, 1, 1'b0, 1'b0));

    rstn = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    in_tag = '0;
    out_ready = 1'b1;
    cur = vec[0];
    repeat (3) tick();
    check("reset out_valid", 32'(out_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset out_quotient", 32'(out_quotient), 0);
    check("reset out_remainder", 32'(out_remainder), 0);
    check("reset out_tag", 32'(out_tag), 0);
    check("reset out_div0", 32'(out_div0), 0);
    check("reset out_ovf", 32'(out_ovf), 0);
    check("reset in_ready", 32'(in_ready), 1);
    rstn = 1'b1;
    tick();

    // single op latency and busy fall
    v = mk(100, 7, 14, 2, 1'b0, 1'b0);
    v.tag = 4'd3;
    issue(v);
    in_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("latency", k, N);
    check("busy with result", 32'(busy), 1);
    tick();
    check("out_valid after accept", 32'(out_valid), 0);
    check("busy after accept", 32'(busy), 0);
    drain();

    // back-to-back: 0..7 / 3, one result per cycle
    for (int i = 0; i < 8; i++) issue(vec[i]);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    run = 0;
    while (out_valid && run < 20) begin
      run++;
      tick();
    end
    check("back_to_back run length", run, 8);
    drain();

    // full pipeline, output stalled for three cycles, then bubbles on refill
    fork
      begin
        for (int i = 8; i < nvec; i++) issue(vec[i]);
        for (int i = 0; i < 8; i++) begin
          issue(vec[i]);
          in_valid = 1'b0;
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        k = 0;
        while (!out_valid && k < 50) begin
          tick();
          k++;
        end
        if (!out_valid) begin
          fail_now("stall_wait", "no result before stall window");
        end else begin
          out_ready = 1'b0;
          cap = {out_quotient, out_remainder, out_tag, out_div0, out_ovf};
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready", 32'(in_ready), 0);
            check("stall out_valid", 32'(out_valid), 1);
            check("stall busy", 32'(busy), 1);
            check("stall output hold", {out_quotient, out_remainder, out_tag, out_div0, out_ovf}, cap);
            tick();
          end
          out_ready = 1'b1;
        end
      end
    join
    drain();

    // reset with ops in flight, then a fresh op
    for (int i = 0; i < 4; i++) issue(vec[i]);
    in_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midreset out_valid", 32'(out_valid), 0);
    check("midreset busy", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("no results after reset", cnt, 0);
    v = mk(9, 2, 4, 1, 1'b0, 1'b0);
    v.tag = 4'd9;
    issue(v);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      tick();
      k++;
    end
    check("post-reset result valid", 32'(out_valid), 1);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_divider.md
Name: pipelined_divider

Overview:
Fully pipelined, parametrised integer divider that computes an N-bit quotient and an M-bit remainder, one quotient bit per stage. It accepts a new operation every cycle through a valid/ready handshake and applies backpressure with a global stall. A tag travels with each operation, and dedicated flags report divide-by-zero and signed overflow. It sits between the datapath issue logic and any consumer that needs throughput-1 division.

Parameters:
N, 8, dividend and quotient width (N >= M, N >= 2)
M, 4, divisor and remainder width (M >= 2)
TAG_W, 4, width of the opaque sideband tag carried with each operation

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation this cycle
in_dividend  input  N  dividend
in_divisor  input  M  divisor
in_tag  input  TAG_W  sideband tag, returned unchanged with the result
out_valid  output  1  result presented
out_ready  input  1  consumer accepts the result
out_quotient  output  N  quotient
out_remainder  output  M  remainder
out_tag  output  TAG_W  tag of this result
out_div0  output  1  divisor was zero
out_ovf  output  1  signed overflow; always 0 without the macro
busy  output  1  at least one stage holds a valid operation

Behaviour:
- Reset (rstn low at a clock edge): all stage valid bits clear.
  - out_valid=0, busy=0, out_quotient=0, out_remainder=0, out_tag=0, out_div0=0, out_ovf=0.
  - Operations in flight are discarded; none reappear after reset.
- Advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Accept: the operation is accepted when in_valid && in_ready.
- Stall: when adv=0, every stage holds its data and valid bit; outputs stay stable until accepted.
- Pipeline: N stages. Stage k (k = N-1 down to 0):
  - Partial remainder R (M+1 bits) becomes {R[M-1:0], dividend bit k}.
  - If R >= {0,divisor}: subtract and set quotient bit k to 1.
  - Otherwise the quotient bit is 0 and R is unchanged.
- Carried per stage: divisor, remaining dividend bits, partial quotient, tag, div0, ovf and sign flags.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+N, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one result per cycle. Results leave in strict issue order.
- Bubbles: in_valid=0 on an advancing cycle inserts an invalid stage. Bubbles are not compressed.
- Data on bubbles is don't-care, but it must not toggle outputs while out_valid=0. The output register only loads when a valid result enters it.
- Divide by zero (divisor == 0):
  - quotient = all ones, remainder = in_dividend[M-1:0], div0=1.
  - The operation still takes the full latency.
- Width rules:
  - Unsigned remainder < divisor, so it always fits in M bits.
  - Subtraction is done at M+1 bits; no truncation is permitted before the compare.
- Simultaneous output accept and new input: both occur. The pipeline advances by one.
- busy = OR of all stage valid bits, including the output stage.

Optional Feature:
Macro DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - The first stage converts operands to magnitudes and records the signs.
  - The last stage negates the quotient if the signs differ, and negates the remainder if the dividend was negative. The quotient truncates toward zero.
  - Signed overflow (dividend = -2^(N-1), divisor = -1): quotient = dividend, remainder = 0, ovf=1.
  - Divide by zero: quotient = all ones, remainder = dividend[M-1:0], div0=1.
  - Latency is unchanged.
- Undefined: unsigned only, sign logic absent, out_ovf tied to 0.

Test Plan:
- 100/7, tag 3, out_ready=1 -> after exactly 8 cycles: q=14, r=2, tag=3, div0=0; busy falls one cycle after the result is accepted.
- 8 back-to-back ops, dividends 0..7 with divisor 3, out_ready=1 -> 8 consecutive results in order with correct q and r (e.g. 7 gives q=2, r=1), one per cycle.
- Pipeline full, out_ready low for 3 cycles -> in_ready=0 for those 3 cycles; output fields stable; after release all results arrive in order with none lost or duplicated.
- 37/0 -> q=0xFF, r=0x5, div0=1. Then 255/15 -> q=17, r=0, div0=0.
- 4 ops in flight, then rstn low for one cycle -> out_valid=0 and busy=0 after that edge; no stale results afterwards; a new op 9/2 returns q=4, r=1.
- With DIVIDER_SIGNED_EN:
  - -100/7 -> q=0xF2 (-14), r=0xE (-2).
  - -128/-1 -> q=0x80, r=0, ovf=1.
  - 100/-7 -> q=0xF2, r=0x2.
